// File: rtl/fifo_rr_drain.sv
// rtl/fifo_rr_drain.sv - round-robin drain of CHANNELS show-behind FIFOs into one tagged valid/ready stream
// Bursts are capped at MAX_BURST reads per grant; a 2-entry buffer absorbs the one-cycle FIFO read latency.
module fifo_rr_drain #(
    parameter int CHANNELS  = 4,
    parameter int DWIDTH    = 64,
    parameter int MAX_BURST = 4,
    localparam int CHW      = $clog2(CHANNELS)
) (
    input  logic                         clk_i,
    input  logic                         srst_i,
    input  logic [CHANNELS-1:0]          fifo_empty_i,
    input  logic [CHANNELS*DWIDTH-1:0]   fifo_q_i,
    output logic [CHANNELS-1:0]          fifo_rdreq_o,
    output logic [DWIDTH-1:0]            data_o,
    output logic [CHW-1:0]               channel_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         busy_o
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CHW-1:0]      r_cur;
    logic [CHW-1:0]      r_last;
    logic [7:0]          r_cnt;
    logic                r_inflight;
    logic [CHW-1:0]      r_inflight_ch;
    logic [DWIDTH-1:0]   r_buf_data [2];
    logic [CHW-1:0]      r_buf_ch [2];
    logic [1:0]          r_occ;
    logic                r_head;

    logic                w_found;
    logic [CHW-1:0]      w_sel;
    logic [CHW-1:0]      w_idx;
    logic                w_cur_empty;
    logic [DWIDTH-1:0]   w_q;
    logic                w_pop;
    logic                w_credit;
    logic                w_issue;
    logic                w_wr_idx;

    assign valid_o   = (r_occ != 2'd0);
    assign data_o    = r_buf_data[r_head];
    assign channel_o = r_buf_ch[r_head];
    assign busy_o    = (r_state != S_IDLE) || r_inflight || valid_o;

    assign w_pop    = valid_o && ready_i;
    // Occupancy after this cycle's capture and pop must leave room for the word a new read returns.
    assign w_credit = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_issue  = srst_i && (r_state == S_BURST) && !w_cur_empty && w_credit;
    assign w_wr_idx = r_head ^ r_occ[0];

    always_comb begin
        w_cur_empty = 1'b1;
        w_q         = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CHW'(c) == r_cur)
                w_cur_empty = fifo_empty_i[c];
            if (CHW'(c) == r_inflight_ch)
                w_q = fifo_q_i[c*DWIDTH +: DWIDTH];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            w_idx = CHW'((int'(r_last) + i) % CHANNELS);
            if (!w_found && !fifo_empty_i[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        fifo_rdreq_o = '0;
        if (w_issue)
            fifo_rdreq_o[r_cur] = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_found)
                    w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (w_cur_empty || (w_issue && (r_cnt == 8'(MAX_BURST - 1))))
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_last        <= CHW'(CHANNELS - 1);
            r_cnt         <= '0;
            r_inflight    <= 1'b0;
            r_inflight_ch <= '0;
            r_occ         <= '0;
            r_head        <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                r_buf_data[k] <= '0;
                r_buf_ch[k]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_found) begin
                r_cur  <= w_sel;
                r_last <= w_sel;
                r_cnt  <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_inflight <= w_issue;
            if (w_issue)
                r_inflight_ch <= r_cur;
            // At occ=2 the write slot is the head being popped in the same cycle.
            if (r_inflight) begin
                r_buf_data[w_wr_idx] <= w_q;
                r_buf_ch[w_wr_idx]   <= r_inflight_ch;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb/tb_fifo_rr_drain.sv - directed and random bench for fifo_rr_drain with FIFO models and a per-channel scoreboard
module tb_fifo_rr_drain;

    localparam int CH = 4;
    localparam int DW = 64;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              srst_i;
    logic              ready_i;
    logic [CH-1:0]     fifo_empty = '1;
    logic [CH-1:0]     fifo_rdreq;
    logic [CH*DW-1:0]  fifo_q;
    logic [DW-1:0]     data_o;
    logic [1:0]        channel_o;
    logic              valid_o;
    logic              busy_o;

    logic [DW-1:0]     q_r [CH] = '{default: '0};
    logic [DW-1:0]     fq [CH][$];
    logic [CH-1:0]     load_en;
    logic [DW-1:0]     load_data [CH];

    logic [DW-1:0]     exp_q [CH][$];
    int                out_ch[$];
    int                out_cyc[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                test_id = 0;
    logic              prev_stall;
    logic [DW-1:0]     prev_data;
    logic [1:0]        prev_ch;

    int                g, t_ne, idx3, n_before, t1, t3;
    int                loaded [CH];
    int                exp_ch, exp_dt;

    always #5 clk = ~clk;

    assign fifo_q = {q_r[3], q_r[2], q_r[1], q_r[0]};

    fifo_rr_drain #(.CHANNELS(CH), .DWIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i        (clk),
        .srst_i       (srst_i),
        .fifo_empty_i (fifo_empty),
        .fifo_q_i     (fifo_q),
        .fifo_rdreq_o (fifo_rdreq),
        .data_o       (data_o),
        .channel_o    (channel_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o)
    );

    // Show-behind FIFO: q updates one cycle after rdreq, empty lags the last read by one cycle.
    always @(posedge clk) begin : fifo_model
        logic [DW-1:0] v;
        for (int c = 0; c < CH; c++) begin
            if (!srst_i) begin
                fq[c].delete();
            end else begin
                if (fifo_rdreq[c] && fq[c].size() != 0) begin
                    v = fq[c].pop_front();
                    q_r[c] <= v;
                end
                if (load_en[c])
                    fq[c].push_back(load_data[c]);
            end
            fifo_empty[c] <= (fq[c].size() == 0);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int c, input int k);
        return {16'(test_id), 16'(c), 32'(k)};
    endfunction

    task automatic load(input int c, input logic [DW-1:0] d);
        load_en[c]   = 1'b1;
        load_data[c] = d;
        exp_q[c].push_back(d);
    endtask

    function automatic bit sb_pending();
        for (int c = 0; c < CH; c++)
            if (exp_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        check("rdreq_onehot0", 64'($onehot0(fifo_rdreq)), 64'd1);
        if (srst_i && prev_stall) begin
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_data", data_o, prev_data);
            check("stall_ch", 64'(channel_o), 64'(prev_ch));
        end
        if (srst_i && valid_o && ready_i) begin
            check("sb_has_word", 64'(exp_q[channel_o].size() != 0), 64'd1);
            if (exp_q[channel_o].size() != 0) begin
                e = exp_q[channel_o].pop_front();
                check("sb_data", data_o, e);
            end
            out_ch.push_back(int'(channel_o));
            out_cyc.push_back(cyc);
        end
        prev_stall = srst_i && valid_o && !ready_i;
        prev_data  = data_o;
        prev_ch    = channel_o;
        @(posedge clk);
        cyc++;
        #1;
        load_en = '0;
    endtask

    task automatic do_reset();
        srst_i = 1'b0;
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        tick();
        tick();
        srst_i     = 1'b1;
        prev_stall = 1'b0;
        out_ch.delete();
        out_cyc.delete();
        test_id++;
    endtask

    task automatic drain(input string tag, input int limit);
        int n = 0;
        ready_i = 1'b1;
        while ((busy_o || (fifo_empty != '1) || sb_pending()) && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_drain_in_time"}, 64'(n < limit), 64'd1);
        for (int c = 0; c < CH; c++)
            check({tag, "_sb_empty"}, 64'(exp_q[c].size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        srst_i  = 1'b0;
        ready_i = 1'b0;
        load_en = '0;
        for (int c = 0; c < CH; c++) load_data[c] = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ch    = '0;
        tick();
        tick();
        check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_data", data_o, 64'd0);
        check("rst_channel", 64'(channel_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);

        // Two words on channel 2: latency, back-to-back output, busy drop.
        do_reset();
        ready_i = 1'b1;
        load(2, word(2, 0));
        tick();
        t_ne = cyc;
        load(2, word(2, 1));
        tick();
        g = 0;
        while (!valid_o && g < 10) begin tick(); g++; end
        check("t1_latency", 64'(cyc - t_ne), 64'd3);
        check("t1_a_data", data_o, word(2, 0));
        check("t1_a_ch", 64'(channel_o), 64'd2);
        tick();
        check("t1_b_valid", 64'(valid_o), 64'd1);
        check("t1_b_data", data_o, word(2, 1));
        check("t1_b_ch", 64'(channel_o), 64'd2);
        tick();
        check("t1_end_valid", 64'(valid_o), 64'd0);
        check("t1_end_busy", 64'(busy_o), 64'd0);

        // Ten words on every channel: grant order, burst length and bubble spacing.
        do_reset();
        ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < CH; c++) load(c, word(c, k));
            tick();
        end
        ready_i = 1'b1;
        g = 0;
        while (out_ch.size() < 40 && g < 300) begin tick(); g++; end
        check("t2_count", 64'(out_ch.size()), 64'd40);
        for (int k = 0; k < 40 && k < out_ch.size(); k++) begin
            exp_ch = (k < 32) ? (k / 4) % 4 : (k - 32) / 2;
            check("t2_grant_ch", 64'(out_ch[k]), 64'(exp_ch));
            if (k > 0) begin
                if (k < 32) exp_dt = (k % 4 == 0) ? 2 : 1;
                else        exp_dt = (k == 32) ? 2 : ((k % 2 == 0) ? 3 : 1);
                check("t2_spacing", 64'(out_cyc[k] - out_cyc[k-1]), 64'(exp_dt));
            end
        end
        drain("t2", 100);

        // Channel 1 refilled every cycle, a single word on channel 3 must not starve.
        do_reset();
        ready_i = 1'b1;
        t_ne = 0;
        for (int k = 0; k < 40; k++) begin
            load(1, word(1, k));
            if (k == 20) load(3, word(3, 0));
            tick();
            if (k == 20) t_ne = cyc;
        end
        drain("t3", 400);
        idx3 = -1;
        for (int k = 0; k < out_ch.size(); k++)
            if (idx3 < 0 && out_ch[k] == 3) idx3 = k;
        check("t3_ch3_seen", 64'(idx3 > 0), 64'd1);
        if (idx3 > 0) begin
            n_before = 0;
            for (int k = 0; k < idx3; k++)
                if (out_ch[k] == 1 && out_cyc[k] >= t_ne) n_before++;
            check("t3_ch1_words_before", 64'(n_before <= MB + 1), 64'd1);
            t1 = out_cyc[idx3-1];
            t3 = out_cyc[idx3];
            check("t3_gap_after_burst", 64'((t3 - t1) <= MB + 1), 64'd1);
        end

        // Backpressure during a channel 0 burst.
        do_reset();
        ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load(0, word(0, k));
            tick();
        end
        for (int k = 0; k < 6; k++) tick();
        check("t4_valid", 64'(valid_o), 64'd1);
        check("t4_head_data", data_o, word(0, 0));
        check("t4_head_ch", 64'(channel_o), 64'd0);
        check("t4_rdreq_held", 64'(fifo_rdreq), 64'd0);
        check("t4_words_left", 64'(fq[0].size()), 64'd4);
        tick();
        tick();
        check("t4_rdreq_still", 64'(fifo_rdreq), 64'd0);
        drain("t4", 100);
        check("t4_count", 64'(out_ch.size()), 64'd6);

        // Random ready over 1000 words, 250 per channel.
        do_reset();
        for (int c = 0; c < CH; c++) loaded[c] = 0;
        g = 0;
        while (out_ch.size() < 1000 && g < 20000) begin
            for (int c = 0; c < CH; c++) begin
                if (loaded[c] < 250 && $urandom_range(0, 3) != 0) begin
                    load(c, word(c, loaded[c]));
                    loaded[c]++;
                end
            end
            ready_i = 1'($urandom_range(0, 1));
            tick();
            g++;
        end
        check("t5_count", 64'(out_ch.size()), 64'd1000);
        drain("t5", 100);

        // Reset with a full output buffer, then channel 0 regains first priority.
        do_reset();
        ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load(2, word(2, k));
            tick();
        end
        for (int k = 0; k < 4; k++) tick();
        check("t6_full_valid", 64'(valid_o), 64'd1);
        check("t6_full_rdreq", 64'(fifo_rdreq), 64'd0);
        srst_i = 1'b0;
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        tick();
        check("t6_rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("t6_rst_valid", 64'(valid_o), 64'd0);
        check("t6_rst_data", data_o, 64'd0);
        check("t6_rst_channel", 64'(channel_o), 64'd0);
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        srst_i     = 1'b1;
        prev_stall = 1'b0;
        out_ch.delete();
        out_cyc.delete();
        ready_i = 1'b1;
        tick();
        load(3, word(3, 0));
        load(0, word(0, 0));
        tick();
        g = 0;
        while (out_ch.size() < 1 && g < 20) begin tick(); g++; end
        check("t6_first_grant", 64'((out_ch.size() > 0) ? out_ch[0] : -1), 64'd0);
        drain("t6", 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Round-robin read scheduler that drains CHANNELS instances of the team FIFO into a single valid/ready output stream.
- FIFOs are configured SHOWAHEAD=0, REGISTER_OUTPUT=0, so q is valid exactly one cycle after an accepted rdreq.
- Each output word is tagged with its source channel.
- Sits between per-source FIFOs and a shared downstream consumer.
- Bounds per-grant bursts so that no channel can starve the others.

Parameters:
CHANNELS, 4, number of drained FIFOs (2..16)
DWIDTH, 64, data width; must match the FIFO DWIDTH
MAX_BURST, 4, maximum reads issued per grant before rotation (1..255)
CHW, $clog2(CHANNELS), channel tag width (derived, not overridable)

Ports:
clk_i  in  1  single clock
srst_i  in  1  synchronous reset, active-low (0 = reset)
fifo_empty_i  in  CHANNELS  empty_o of each FIFO, bit n = channel n
fifo_q_i  in  CHANNELS*DWIDTH  q_o of each FIFO, channel n at [n*DWIDTH +: DWIDTH]
fifo_rdreq_o  out  CHANNELS  rdreq_i to each FIFO, at most one bit set
data_o  out  DWIDTH  output word
channel_o  out  CHW  source channel of data_o
valid_o  out  1  data_o/channel_o valid
ready_i  in  1  downstream accepts when valid_o && ready_i
busy_o  out  1  1 when FSM is not IDLE, a read is in flight, or the buffer is non-empty

Behaviour:
- Reset (srst_i=0 at a clock edge):
  - fifo_rdreq_o=0, valid_o=0, data_o=0, channel_o=0, busy_o=0.
  - Buffer and in-flight flag are cleared; FSM goes to IDLE.
  - Round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
  - Reset mid-burst discards any in-flight word and all buffered words.
- Output buffer:
  - 2-entry FIFO with occupancy occ (0..2); data_o/channel_o/valid_o are driven from its head.
  - valid_o=1 when occ!=0.
  - Once valid_o is asserted, data_o and channel_o hold stable until the handshake completes.
  - Output order equals read issue order.
- Read credit:
  - inflight=1 in the cycle after an rdreq was issued.
  - pop = valid_o && ready_i.
  - A read may be issued only if occ + inflight - pop < 2.
  - This guarantees no overflow and allows 1 word/cycle when ready_i is held high.
- Capture: when inflight=1, fifo_q_i of the registered in-flight channel is written into the buffer with that channel tag. A simultaneous pop and capture is legal.
- FSM:
  - IDLE:
    - Search channels last+1, last+2, … (mod CHANNELS) for the first with fifo_empty_i=0.
    - If found: cur<=that channel, last<=that channel, cnt<=0, go to BURST.
    - No rdreq is issued in IDLE, giving 1 bubble cycle per grant.
  - BURST:
    - fifo_rdreq_o[cur]=1 iff fifo_empty_i[cur]=0 and credit allows; each issue does cnt<=cnt+1.
    - Go to IDLE when an issue makes cnt reach MAX_BURST, or when fifo_empty_i[cur]=1 is sampled.
    - A credit stall alone does not end the burst.
  - When all channels are empty, the FSM stays in IDLE and last is unchanged.
- Empty handling:
  - The FIFO empty flag updates one cycle after the read of its last word.
  - The FIFO internally gates rdreq when empty, so one possible over-issue on the last word is harmless: no capture occurs.
  - Accordingly, inflight is set only when fifo_empty_i[cur]=0 at issue.
- Widths:
  - cnt is 8 bits.
  - The pointer wraps modulo CHANNELS; non-power-of-2 CHANNELS wraps from CHANNELS-1 to 0.
- Latency: first word reaches valid_o 3 cycles after a channel goes non-empty in IDLE (arbitrate, read, capture).

Test Plan:
- Reset, then channel 2 holds words A,B, ready_i=1 -> valid_o rises 3 cycles later; outputs A then B on consecutive cycles with channel_o=2; busy_o drops after B.
- All 4 channels hold 10 words, MAX_BURST=4, ready_i=1:
  - Grant order is 0,1,2,3,0,…
  - Each grant produces 4 words, separated by 1 idle cycle.
  - Per-channel order is preserved; total 40 words.
- Channel 1 continuously refilled, channel 3 holds 1 word -> channel 3's word appears within 4+1 cycles after channel 1's current burst ends (no starvation).
- ready_i=0 during a burst on channel 0 -> at most 2 words buffered, fifo_rdreq_o=0 afterwards, data_o stable. Raising ready_i drains the words in order with no loss or duplication.
- Random ready_i toggling with a scoreboard over 1000 words on 4 channels -> every word is delivered exactly once, with the correct channel tag and in per-channel order.
- srst_i=0 asserted mid-burst with occ=2 -> next cycle all outputs are 0 and the FSM is IDLE. After release, channel 0 is granted first if non-empty.
